imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, buffered immediate generator for the RISC-V decode stage.
//  - Accepts a 32-bit instruction plus a 3-bit format select over a valid/ready handshake.
//  - Produces the XLEN-wide extended immediate (I/S/B/J/U/Z formats) one cycle later.
//  - Output sits in a DEPTH-entry FIFO feeding the execute-stage operand mux.
//  - Out-of-range selects return an error flag.
// PARAMETERS
//  XLEN   32  output immediate width; legal values 32 or 64
//  DEPTH  2   output FIFO entries; must be >= 1, need not be a power of two
// PORTS
//  clk        in   1     single clock, rising edge
//  reset      in   1     synchronous, active-high
//  in_valid   in   1     instr/ImmSrc valid this cycle
//  in_ready   out  1     block can accept this cycle
//  instr      in   32    raw instruction word
//  ImmSrc     in   3     format select (encoding below)
//  out_valid  out  1     ImmExt/imm_err hold a valid entry (FIFO head)
//  out_ready  in   1     consumer takes head this cycle
//  ImmExt     out  XLEN  extended immediate at FIFO head
//  imm_err    out  1     head entry came from an illegal ImmSrc
//  occupancy  out  $clog2(DEPTH+1)  FIFO entry count
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
//  - Reset (sampled at posedge clk):
//    - FIFO emptied; read and write pointers set to 0.
//    - out_valid=0, occupancy=0, ImmExt=0, imm_err=0.
//    - in_ready=1 in the first cycle after reset deasserts.
//    - Reset mid-stream discards all held entries; no output handshake completes in the reset cycle.
//  - Decode (combinational, applied at push; i = instr):
//    - 000 I: sext(i[31:20])
//    - 001 S: sext({i[31:25],i[11:7]})
//    - 010 B: sext({i[31],i[7],i[30:25],i[11:8],1'b0})
//    - 011 J: sext({i[31],i[19:12],i[20],i[30:21],1'b0})
//    - 100 U: sext({i[31:12],12'b0}). With XLEN=64, bit 31 is replicated into [63:32].
//    - 101 Z: zext(i[19:15]) (CSR uimm)
//    - 110/111: ImmExt=0, imm_err=1. The entry is still pushed and keeps its ordering.
//    - sext/zext always extend to the full XLEN. imm_err=0 for every legal select.
//  - Handshake:
//    - Push when in_valid && in_ready; pop when out_valid && out_ready.
//    - in_ready = (occupancy<DEPTH) || (out_valid && out_ready): a full FIFO still accepts when popping in the same cycle.
//    - in_ready must not depend on in_valid.
//    - Once out_valid=1, ImmExt and imm_err hold stable until the pop.
//  - Latency: an entry pushed at edge N is visible at the head after edge N (out_valid=1 in cycle N+1) when the FIFO was empty. There is no combinational in->out path.
//  - Occupancy:
//    - push only: +1; pop only: -1; push and pop together: unchanged.
//    - Pointers wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
//    - Pop when empty and push when full without a pop are impossible by construction. Assertions check both.
//  - Throughput: one immediate per cycle sustained while out_ready=1.
// TESTING
//  1. Reset, then check: out_valid=0, occupancy=0, ImmExt=0, imm_err=0, in_ready=1.
//  2. Single pushes, XLEN=32, out_ready=1. Each row gives ImmSrc, instr -> ImmExt:
//     - I, 0xFFC4A303 -> 0xFFFFFFFC
//     - S, 0x0064A423 -> 0x00000008
//     - B, 0xFE420AE3 -> 0xFFFFFFF4
//     - J, 0x008000EF -> 0x00000008
//     - U, 0x123452B7 -> 0x12345000
//     - Z, 0x0002D073 -> 0x00000005
//     Each result appears exactly 1 cycle after its push.
//  3. XLEN=64, U, instr 0x80000037 -> ImmExt=0xFFFFFFFF80000000. B, 0xFE420AE3 -> 0xFFFFFFFFFFFFFFF4.
//  4. ImmSrc=110 between two I pushes: the middle output is ImmExt=0, imm_err=1. Order is preserved and the neighbours have imm_err=0.
//  5. DEPTH=2, out_ready=0, continuous in_valid:
//     - Exactly 2 accepted, then in_ready=0 and occupancy=2.
//     - Raise out_ready with in_valid still high: push and pop happen in the same cycle and occupancy stays 2.
//     - DEPTH=3 run checks pointer wrap.
//  6. Assert reset with occupancy=2: the next cycle shows out_valid=0 and occupancy=0. Stale entries never appear afterwards.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// RISC-V immediate generator with a small output FIFO between decode and the execute operand mux.
// The immediate is decoded as the instruction is accepted; the consumer only sees registered FIFO state.
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [2:0]                 ImmSrc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            ImmExt,
  output logic                       imm_err,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [DEPTH-1:0] err_mem_q;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             push, pop;

  // Format decode; selects 110/111 still produce an entry, flagged as an error.
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (ImmSrc)
      3'b000: dec_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      3'b001: dec_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: dec_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: dec_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b100: dec_imm = XLEN'($signed({instr[31:12], 12'h000}));
      3'b101: dec_imm = XLEN'(instr[19:15]);
      default: dec_err = 1'b1;
    endcase
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign in_ready  = (count_q < DepthCnt) || pop;
  assign push      = in_valid && in_ready;
  assign occupancy = count_q;
  assign ImmExt    = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign imm_err   = out_valid ? err_mem_q[rd_ptr_q] : 1'b0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: out_valid masks entries that were never written.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      imm_mem_q[wr_ptr_q] <= dec_imm;
      err_mem_q[wr_ptr_q] <= dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && count_q == '0));
      assert (!(push && !pop && count_q == DepthCnt));
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three instances (XLEN32/D2, XLEN64/D2, XLEN32/D3) share one stimulus
// stream; each has its own scoreboard queue filled on push and drained on pop.
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  ImmSrc;

  logic        ir32, ov32, err32;
  logic [31:0] imm32;
  logic [1:0]  occ32;
  logic        ir64, ov64, err64;
  logic [63:0] imm64;
  logic [1:0]  occ64;
  logic        ir3, ov3, err3;
  logic [31:0] imm3;
  logic [1:0]  occ3;

  int  tests_run    = 0;
  int  tests_failed = 0;
  sb_t sbq[3][$];
  sb_t exp_e;

  imm_extend_pipe #(.XLEN(32), .DEPTH(2)) u_d32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir32), .instr(instr),
    .ImmSrc(ImmSrc), .out_valid(ov32), .out_ready(out_ready), .ImmExt(imm32),
    .imm_err(err32), .occupancy(occ32)
  );

  imm_extend_pipe #(.XLEN(64), .DEPTH(2)) u_d64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir64), .instr(instr),
    .ImmSrc(ImmSrc), .out_valid(ov64), .out_ready(out_ready), .ImmExt(imm64),
    .imm_err(err64), .occupancy(occ64)
  );

  imm_extend_pipe #(.XLEN(32), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3), .instr(instr),
    .ImmSrc(ImmSrc), .out_valid(ov3), .out_ready(out_ready), .ImmExt(imm3),
    .imm_err(err3), .occupancy(occ3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sb_t ref_imm(logic [31:0] i, logic [2:0] s);
    sb_t r;
    r.err = 1'b0;
    r.imm = '0;
    case (s)
      3'd0: r.imm = 64'($signed(i[31:20]));
      3'd1: r.imm = 64'($signed({i[31:25], i[11:7]}));
      3'd2: r.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd3: r.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd4: r.imm = 64'($signed({i[31:12], 12'h000}));
      3'd5: r.imm = {59'd0, i[19:15]};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input string name, input int depth, input bit w64,
                           input logic ir, input logic ov, input logic [63:0] imm,
                           input logic err, input logic [1:0] occ,
                           output bit pu, output bit po);
    int          n;
    logic [63:0] e;
    n = sbq[d].size();
    chk({name, " occupancy"}, {62'd0, occ}, 64'(n));
    chk({name, " out_valid"}, {63'd0, ov}, {63'd0, n != 0});
    chk({name, " in_ready"}, {63'd0, ir}, {63'd0, (n < depth) || (n != 0 && out_ready)});
    if (n != 0) begin
      e = sbq[d][0].imm;
      if (!w64) e = {32'd0, e[31:0]};
      chk({name, " ImmExt"}, imm, e);
      chk({name, " imm_err"}, {63'd0, err}, {63'd0, sbq[d][0].err});
    end
    pu = in_valid && ir && !reset;
    po = ov && out_ready && !reset;
  endtask

  task automatic upd(input int d, input bit pu, input bit po);
    if (reset) begin
      sbq[d].delete();
    end else begin
      if (po) void'(sbq[d].pop_front());
      if (pu) sbq[d].push_back(exp_e);
    end
  endtask

  task automatic cycle();
    bit pu0, po0, pu1, po1, pu2, po2;
    #1;
    check_dut(0, "d32", 2, 1'b0, ir32, ov32, {32'd0, imm32}, err32, occ32, pu0, po0);
    check_dut(1, "d64", 2, 1'b1, ir64, ov64, imm64, err64, occ64, pu1, po1);
    check_dut(2, "d3", 3, 1'b0, ir3, ov3, {32'd0, imm3}, err3, occ3, pu2, po2);
    @(posedge clk);
    upd(0, pu0, po0);
    upd(1, pu1, po1);
    upd(2, pu2, po2);
    #1;
  endtask

  task automatic drive_exp(input logic [31:0] i, input logic [2:0] s, input logic [63:0] e64,
                           input logic e_err);
    in_valid   = 1'b1;
    instr      = i;
    ImmSrc     = s;
    exp_e.imm  = e64;
    exp_e.err  = e_err;
  endtask

  task automatic drive(input logic [31:0] i, input logic [2:0] s);
    in_valid = 1'b1;
    instr    = i;
    ImmSrc   = s;
    exp_e    = ref_imm(i, s);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    ImmSrc    = '0;
    exp_e     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset out_valid", {63'd0, ov32}, 64'd0);
    chk("reset occupancy", {62'd0, occ32}, 64'd0);
    chk("reset ImmExt", {32'd0, imm32}, 64'd0);
    chk("reset imm_err", {63'd0, err32}, 64'd0);
    chk("reset in_ready", {63'd0, ir32}, 64'd1);
    chk("reset ImmExt64", imm64, 64'd0);

    // Table of single pushes; each result must be at the head one cycle later.
    out_ready = 1'b1;
    drive_exp(32'hFFC4A303, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0); cycle(); idle(1);
    drive_exp(32'h0064A423, 3'd1, 64'h0000_0000_0000_0008, 1'b0); cycle(); idle(1);
    drive_exp(32'hFE420AE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0); cycle(); idle(1);
    drive_exp(32'h008000EF, 3'd3, 64'h0000_0000_0000_0008, 1'b0); cycle(); idle(1);
    drive_exp(32'h123452B7, 3'd4, 64'h0000_0000_1234_5000, 1'b0); cycle(); idle(1);
    drive_exp(32'h0002D073, 3'd5, 64'h0000_0000_0000_0005, 1'b0); cycle(); idle(1);
    drive_exp(32'h80000037, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0); cycle(); idle(1);

    // Illegal select sandwiched between two I-format pushes, back to back.
    drive_exp(32'h00100093, 3'd0, 64'h0000_0000_0000_0001, 1'b0); cycle();
    drive_exp(32'hFFFFFFFF, 3'd6, 64'h0, 1'b1); cycle();
    drive_exp(32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); cycle();
    drive(32'h12345678, 3'd7); cycle();
    idle(3);

    // Fill with the consumer stalled, then stream with push and pop in the same cycle.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive({12'(k + 16), 20'h0_0000}, 3'd0);
      cycle();
    end
    chk("full occupancy d32", {62'd0, occ32}, 64'd2);
    chk("full in_ready d32", {63'd0, ir32}, 64'd0);
    chk("full occupancy d3", {62'd0, occ3}, 64'd3);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(32'h8000_0000 | (32'(k) << 7) | (32'(k + 3) << 15), 3'(k % 6));
      cycle();
      chk("stream occupancy d32", {62'd0, occ32}, 64'd2);
      chk("stream occupancy d3", {62'd0, occ3}, 64'd3);
    end
    idle(4);

    // Reset while full; stale entries must never reach the head afterwards.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive({12'hABC, 20'(k)}, 3'd0);
      cycle();
    end
    in_valid = 1'b0;
    chk("pre-reset occupancy d32", {62'd0, occ32}, 64'd2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("post-reset out_valid", {63'd0, ov32}, 64'd0);
    chk("post-reset occupancy", {62'd0, occ32}, 64'd0);
    chk("post-reset occupancy d3", {62'd0, occ3}, 64'd0);
    chk("post-reset ImmExt", {32'd0, imm32}, 64'd0);
    out_ready = 1'b1;
    drive(32'h0070_0013, 3'd0); cycle();
    drive(32'h0002D073, 3'd5); cycle();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
